tdc_ts_assemble: RTL and testbench

- Consumer stage directly downstream of the 16-tap fine-interpolation popcount pipeline.
- Captures the coarse counter at each hit strobe and delays it to match the popcount latency.
- Merges the delayed coarse value with the 4-bit fine code into one timestamp.
- Buffers timestamps in a small FIFO with a valid/ready handshake towards readout.

---
 rtl/tdc_ts_assemble.sv | 146 ++++++++++++++
 tb/tb_tdc_ts_assemble.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/tdc_ts_assemble.sv
// Timestamp assembler: delays the coarse count to line up with the popcount fine code, then queues timestamps in a FWFT FIFO.
// Optional macro TS_DROP_CNT_EN adds an 8-bit saturating drop counter output.
module tdc_ts_assemble #(
    parameter int CW         = 12,
    parameter int PIPE_LAT   = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          hit_stb,
    input  logic [CW-1:0]                 coarse_cnt,
    input  logic [3:0]                    fine_code,
    output logic [CW+3:0]                 ts_data,
    output logic                          ts_valid,
    input  logic                          ts_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf,
    input  logic                          ovf_clr
`ifdef TS_DROP_CNT_EN
    ,
    output logic [7:0]                    drop_cnt
`endif
);

    localparam int TW = CW + 4;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    logic [PIPE_LAT-1:0]                vld_q, vld_d;
    logic [PIPE_LAT-1:0][CW-1:0]        coarse_q, coarse_d;
    logic [FIFO_DEPTH-1:0][TW-1:0]      mem_q, mem_d;
    logic [AW-1:0]                      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                      rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]                      count_q, count_d;
    logic [TW-1:0]                      ts_data_q, ts_data_d;
    logic                               ovf_q, ovf_d;

    logic          push_req;
    logic          push;
    logic          pop;
    logic          full;
    logic          drop;
    logic [TW-1:0] push_ts;

    always_comb begin
        vld_d       = vld_q;
        coarse_d    = coarse_q;
        vld_d[0]    = hit_stb;
        coarse_d[0] = coarse_cnt;
        for (int i = 1; i < PIPE_LAT; i++) begin
            vld_d[i]    = vld_q[i-1];
            coarse_d[i] = coarse_q[i-1];
        end
    end

    // The fine code is taken live on the edge where the hit leaves the last pipe stage.
    always_comb begin
        push_req = vld_q[PIPE_LAT-1];
        push_ts  = {coarse_q[PIPE_LAT-1], fine_code};
        full     = (count_q == LW'(FIFO_DEPTH));
        pop      = (count_q != '0) && ts_ready;
        push     = push_req && (!full || pop);
        drop     = push_req && full && !pop;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = push_ts;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + LW'(1);
            2'b01:   count_d = count_q - LW'(1);
            default: count_d = count_q;
        endcase

        // Head is registered so ts_ready never reaches the outputs combinationally.
        ts_data_d = (count_d != '0) ? mem_d[rd_ptr_d] : ts_data_q;

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            coarse_q  <= '0;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ts_data_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            vld_q     <= vld_d;
            coarse_q  <= coarse_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ts_data_q <= ts_data_d;
            ovf_q     <= ovf_d;
        end
    end

    assign ts_data    = ts_data_q;
    assign ts_valid   = (count_q != '0);
    assign fifo_level = count_q;
    assign ovf        = ovf_q;

`ifdef TS_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (drop && ovf_clr) begin
            drop_cnt_d = 8'd1;
        end else if (ovf_clr) begin
            drop_cnt_d = 8'd0;
        end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt_q <= 8'd0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_tdc_ts_assemble.sv
// Directed bench for tdc_ts_assemble at default parameters (CW=12, PIPE_LAT=5, FIFO_DEPTH=4).
module tb_tdc_ts_assemble;

    logic        clk = 1'b0;
    logic        rst;
    logic        hit_stb;
    logic [11:0] coarse_cnt;
    logic [3:0]  fine_code;
    logic [15:0] ts_data;
    logic        ts_valid;
    logic        ts_ready;
    logic [2:0]  fifo_level;
    logic        ovf;
    logic        ovf_clr;
`ifdef TS_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tdc_ts_assemble #(
        .CW(12),
        .PIPE_LAT(5),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .hit_stb(hit_stb),
        .coarse_cnt(coarse_cnt),
        .fine_code(fine_code),
        .ts_data(ts_data),
        .ts_valid(ts_valid),
        .ts_ready(ts_ready),
        .fifo_level(fifo_level),
        .ovf(ovf),
        .ovf_clr(ovf_clr)
`ifdef TS_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    // Drive one cycle's inputs, then let that cycle end; outputs are looked at 1 time unit after the edge.
    task automatic applyStimulus(input logic hit, input logic [11:0] coarse, input logic [3:0] fine,
                                 input logic ready, input logic clr);
        hit_stb    = hit;
        coarse_cnt = coarse;
        fine_code  = fine;
        ts_ready   = ready;
        ovf_clr    = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(0, 12'h000, 4'h0, 0, 0);
        applyStimulus(0, 12'h000, 4'h0, 0, 0);
        checkOutput("rst_valid", 32'(ts_valid), 32'd0);
        checkOutput("rst_data", 32'(ts_data), 32'h0);
        checkOutput("rst_level", 32'(fifo_level), 32'd0);
        checkOutput("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;

        applyStimulus(0, 12'h000, 4'h0, 1, 0);
        checkOutput("empty_ready_level", 32'(fifo_level), 32'd0);
        checkOutput("empty_ready_valid", 32'(ts_valid), 32'd0);

        $display("[TB] single hit");
        applyStimulus(1, 12'h123, 4'h0, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 12'h123, 4'h0, 0, 0);
        checkOutput("single_valid_c5", 32'(ts_valid), 32'd0);
        applyStimulus(0, 12'h124, 4'h7, 0, 0);
        checkOutput("single_valid_c6", 32'(ts_valid), 32'd1);
        checkOutput("single_data_c6", 32'(ts_data), 32'h1237);
        checkOutput("single_level_c6", 32'(fifo_level), 32'd1);
        applyStimulus(0, 12'h125, 4'h7, 1, 0);
        checkOutput("single_valid_c7", 32'(ts_valid), 32'd0);
        checkOutput("single_level_c7", 32'(fifo_level), 32'd0);
        checkOutput("single_hold_c7", 32'(ts_data), 32'h1237);

        $display("[TB] back-to-back hits");
        for (int i = 0; i < 4; i++) applyStimulus(1, 12'(10 + i), 4'h0, 0, 0);
        applyStimulus(0, 12'h000, 4'h0, 0, 0);
        for (int i = 1; i <= 4; i++) applyStimulus(0, 12'h000, 4'(i), 0, 0);
        checkOutput("b2b_level", 32'(fifo_level), 32'd4);
        checkOutput("b2b_head", 32'(ts_data), 32'h00A1);
        checkOutput("b2b_ovf", 32'(ovf), 32'd0);

        $display("[TB] overflow");
        applyStimulus(1, 12'h0FF, 4'h0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 12'h000, 4'h0, 0, 0);
        checkOutput("ovf_before_drop", 32'(ovf), 32'd0);
        applyStimulus(0, 12'h000, 4'h5, 0, 0);
        checkOutput("ovf_set", 32'(ovf), 32'd1);
        checkOutput("ovf_level", 32'(fifo_level), 32'd4);
        checkOutput("ovf_head", 32'(ts_data), 32'h00A1);
`ifdef TS_DROP_CNT_EN
        checkOutput("drop_cnt_one", 32'(drop_cnt), 32'd1);
`endif
        applyStimulus(0, 12'h000, 4'h5, 0, 1);
        checkOutput("ovf_cleared", 32'(ovf), 32'd0);
`ifdef TS_DROP_CNT_EN
        checkOutput("drop_cnt_zero", 32'(drop_cnt), 32'd0);
`endif

        $display("[TB] full with push and pop together");
        applyStimulus(1, 12'h055, 4'h0, 0, 0);
        for (int i = 0; i < 4; i++) applyStimulus(0, 12'h000, 4'h0, 0, 0);
        applyStimulus(0, 12'h000, 4'h6, 1, 0);
        checkOutput("pp_level", 32'(fifo_level), 32'd4);
        checkOutput("pp_ovf", 32'(ovf), 32'd0);
        checkOutput("pp_head", 32'(ts_data), 32'h00B2);
        applyStimulus(0, 12'h000, 4'h6, 1, 0);
        checkOutput("drain_1", 32'(ts_data), 32'h00C3);
        applyStimulus(0, 12'h000, 4'h6, 1, 0);
        checkOutput("drain_2", 32'(ts_data), 32'h00D4);
        applyStimulus(0, 12'h000, 4'h6, 1, 0);
        checkOutput("drain_3", 32'(ts_data), 32'h0556);
        checkOutput("drain_3_level", 32'(fifo_level), 32'd1);
        applyStimulus(0, 12'h000, 4'h6, 1, 0);
        checkOutput("drain_empty_valid", 32'(ts_valid), 32'd0);
        checkOutput("drain_empty_level", 32'(fifo_level), 32'd0);

        $display("[TB] reset mid-flight");
        applyStimulus(1, 12'h321, 4'h0, 0, 0);
        applyStimulus(1, 12'h322, 4'h0, 0, 0);
        applyStimulus(0, 12'h000, 4'h0, 0, 0);
        rst = 1'b1;
        applyStimulus(0, 12'h000, 4'h9, 0, 0);
        rst = 1'b0;
        checkOutput("midrst_data", 32'(ts_data), 32'h0);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 12'h000, 4'h9, 0, 0);
            checkOutput("midrst_valid", 32'(ts_valid), 32'd0);
            checkOutput("midrst_level", 32'(fifo_level), 32'd0);
        end

        $display("[TB] fine edge codes");
        applyStimulus(1, 12'hFFF, 4'h0, 0, 0);
        applyStimulus(1, 12'hFFF, 4'h0, 0, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 12'h000, 4'h0, 0, 0);
        applyStimulus(0, 12'h000, 4'hF, 0, 0);
        applyStimulus(0, 12'h000, 4'h0, 0, 0);
        checkOutput("edge_level", 32'(fifo_level), 32'd2);
        checkOutput("edge_all_ones", 32'(ts_data), 32'hFFFF);
        applyStimulus(0, 12'h000, 4'h0, 1, 0);
        checkOutput("edge_zero_fine", 32'(ts_data), 32'hFFF0);
        checkOutput("edge_level_after_pop", 32'(fifo_level), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
